// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared definitions for the program_loader boot stage.
//   - FSM state encoding (plain 3-bit constants so older tools can share it)
//   - reset values of the registered outputs
//   - is_busy(): decodes the busy flag from a state value
package program_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LEN   = 3'd1;
    localparam state_t ST_LOAD  = 3'd2;
    localparam state_t ST_CHECK = 3'd3;
    localparam state_t ST_RUN   = 3'd4;
    localparam state_t ST_DONE  = 3'd5;
    localparam state_t ST_ERROR = 3'd6;

    // Reset values of the registered control outputs. The multi-bit outputs
    // (mem_addr, mem_data, run_cycles) all reset to zero.
    localparam state_t RST_STATE   = ST_IDLE;
    localparam logic   RST_MEM_WR  = 1'b0;
    localparam logic   RST_CPU_RST = 1'b1;
    localparam logic   RST_DONE    = 1'b0;
    localparam logic   RST_ERROR   = 1'b0;

    // Busy covers every state that is in the middle of a load or a run.
    function automatic logic is_busy(input state_t st);
        return !((st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERROR));
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// program_loader_if
// Byte-stream valid/ready handshake that feeds the loader.
//   in_valid  producer -> loader   byte on in_data is valid
//   in_data   producer -> loader   stream byte (DWIDTH bits)
//   in_ready  loader   -> producer loader accepts a byte this cycle
// Modports: master = stream producer, slave = program_loader.
interface program_loader_if #(
    parameter int DWIDTH = 8
);
    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/program_loader_sat_counter.sv
// sat_counter
// Clearable up-counter that sticks at all-ones instead of wrapping.
//   clk  rising-edge clock
//   rst  asynchronous active-low reset (count -> 0)
//   clr  synchronous clear, wins over inc
//   inc  count one step this cycle
//   cnt  current count (CWIDTH bits)
module sat_counter #(
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [CWIDTH-1:0] cnt
);

    localparam logic [CWIDTH-1:0] CNT_ONE = {{(CWIDTH-1){1'b0}}, 1'b1};
    localparam logic [CWIDTH-1:0] CNT_MAX = {CWIDTH{1'b1}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader
// Boot stage for the VERI_RISC core. Receives a length-prefixed byte stream,
// writes the program into CPU memory from address 0, holds the core in reset
// until the load is complete, then counts run cycles until the core halts.
//
// Stream format: L, then N program bytes (N = L[AWIDTH-1:0], 0 means
// 2^AWIDTH). When PROGRAM_LOADER_CHECKSUM_EN is defined a trailing byte
// follows, which must equal the DWIDTH-bit sum of L and the N program bytes;
// without the macro the CHECK state and the accumulator do not exist.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   start       one-cycle load request (IDLE / DONE / ERROR only)
//   in_if       byte stream (slave side of program_loader_if)
//   mem_wr      memory write strobe, one cycle per program byte
//   mem_addr    write address
//   mem_data    write data
//   cpu_halt    halt output of the core (looked at only in RUN)
//   cpu_rst     core reset, 1 holds the core in reset
//   busy        in LEN, LOAD, CHECK or RUN
//   done        core halted after a good load
//   error       load failed (bad length or checksum)
//   run_cycles  clocks spent in RUN, saturating
module program_loader
    import program_loader_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    program_loader_if.slave     in_if,
    output logic                mem_wr,
    output logic [AWIDTH-1:0]   mem_addr,
    output logic [DWIDTH-1:0]   mem_data,
    input  logic                cpu_halt,
    output logic                cpu_rst,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [CWIDTH-1:0]   run_cycles
);

    // Byte counts run to 2^AWIDTH, so index and length carry one extra bit.
    localparam logic [AWIDTH:0] MAX_BYTES = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] IDX_ONE   = {{AWIDTH{1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [AWIDTH:0]   idx;        // index of the next program byte
    logic [AWIDTH:0]   nbytes;     // program length latched from L
    logic              accept;
    logic              len_bad;
    logic [AWIDTH:0]   len_n;
    logic              last_byte;
    logic              run_clr;
    logic              run_inc;

    // Ready and busy come straight off the state register.
    assign in_if.in_ready = (state == ST_LEN) || (state == ST_LOAD) ||
                            (state == ST_CHECK);
    assign busy           = is_busy(state);

    assign accept    = in_if.in_valid && in_if.in_ready;
    assign len_bad   = (in_if.in_data >> AWIDTH) != '0;
    assign len_n     = (in_if.in_data[AWIDTH-1:0] == '0) ? MAX_BYTES
                                                         : {1'b0, in_if.in_data[AWIDTH-1:0]};
    assign last_byte = (idx == (nbytes - IDX_ONE));

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running sum of L and every program byte, compared in CHECK.
    logic [DWIDTH-1:0] csum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= '0;
        end else if (accept && (state == ST_LEN)) begin
            csum <= in_if.in_data;
        end else if (accept && (state == ST_LOAD)) begin
            csum <= csum + in_if.in_data;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (accept) state_nxt = len_bad ? ST_ERROR : ST_LOAD;
            end
            ST_LOAD: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (accept && last_byte) state_nxt = ST_CHECK;
`else
                if (accept && last_byte) state_nxt = ST_RUN;
`endif
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept) state_nxt = (in_if.in_data == csum) ? ST_RUN : ST_ERROR;
            end
`endif
            ST_RUN: begin
                if (cpu_halt) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up
    // with the state they describe (cpu_rst falls on the first RUN cycle).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RST_STATE;
            idx      <= '0;
            nbytes   <= '0;
            mem_wr   <= RST_MEM_WR;
            mem_addr <= '0;
            mem_data <= '0;
            cpu_rst  <= RST_CPU_RST;
            done     <= RST_DONE;
            error    <= RST_ERROR;
        end else begin
            state   <= state_nxt;
            mem_wr  <= accept && (state == ST_LOAD);
            cpu_rst <= !((state_nxt == ST_RUN) || (state_nxt == ST_DONE));
            done    <= (state_nxt == ST_DONE);
            error   <= (state_nxt == ST_ERROR);

            if (accept && (state == ST_LEN)) begin
                nbytes <= len_n;
                idx    <= '0;
            end

            // Address comes from the low bits only; idx may reach 2^AWIDTH
            // after the final byte but is never used as an address there.
            if (accept && (state == ST_LOAD)) begin
                mem_addr <= idx[AWIDTH-1:0];
                mem_data <= in_if.in_data;
                idx      <= idx + IDX_ONE;
            end
        end
    end

    // Clear on entry to LEN, count every cycle spent in RUN.
    assign run_clr = (state_nxt == ST_LEN) && (state != ST_LEN);
    assign run_inc = (state == ST_RUN);

    sat_counter #(
        .CWIDTH (CWIDTH)
    ) u_run_cnt (
        .clk (clk),
        .rst (rst),
        .clr (run_clr),
        .inc (run_inc),
        .cnt (run_cycles)
    );

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
module tb_program_loader;
    localparam int AW     = 5;
    localparam int DW     = 8;
    localparam int CW     = 5;
    localparam int MAXCNT = (1 << CW) - 1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          cpu_halt = 1'b0;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          cpu_rst, busy, done, error;
    logic [CW-1:0] run_cycles;

    program_loader_if #(.DWIDTH(DW)) s_if();

    program_loader #(.AWIDTH(AW), .DWIDTH(DW), .CWIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_if      (s_if),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cpu_halt   (cpu_halt),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed writes and cpu_rst falling edge, sampled on the falling clock.
    typedef struct { int cyc; int addr; int data; } wr_t;
    wr_t  wr_q[$];
    int   acc_q[$];      // clock edge number of each accepted stream byte
    int   fall_cyc = -1;
    logic prev_cpu_rst = 1'b1;

    always @(negedge clk) begin
        if (mem_wr === 1'b1) wr_q.push_back('{cyc, int'(mem_addr), int'(mem_data)});
        if (prev_cpu_rst === 1'b1 && cpu_rst === 1'b0) fall_cyc = cyc;
        prev_cpu_rst = cpu_rst;
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if ({s_if.in_ready, busy, done, error, run_cycles} !== {4'b1100, {CW{1'b0}}})
            $display("FAIL start_to_len: ready/busy/done/error/run=%b%b%b%b/%0d want 1100/0",
                     s_if.in_ready, busy, done, error, run_cycles);
        if ({s_if.in_ready, busy, done, error, run_cycles} !== {4'b1100, {CW{1'b0}}}) errors++;
    endtask

    // Feeds bytes with random idle gaps; returns at a falling edge just after
    // the final acceptance edge with in_valid dropped.
    task automatic send_stream(input logic [7:0] bytes[$], input int gap, input bit poke,
                               output bit ok);
        int i = 0;
        int guard = 0;
        acc_q.delete();
        ok = 1'b1;
        while (i < bytes.size()) begin
            @(negedge clk);
            start = poke && (i == 2);
            if (guard > 400) begin
                ok = 1'b0;
                break;
            end
            guard++;
            if ($urandom_range(0, 99) < gap) begin
                s_if.in_valid = 1'b0;
                s_if.in_data  = 8'($urandom);
            end else begin
                s_if.in_valid = 1'b1;
                s_if.in_data  = bytes[i];
                if (s_if.in_ready === 1'b1) begin
                    acc_q.push_back(cyc + 1);
                    i++;
                end
            end
        end
        @(negedge clk);
        s_if.in_valid = 1'b0;
        start = 1'b0;
        #1;
    endtask

    // Reference: builds the stream from L and the program, predicts writes
    // and the final outcome from the stream rules alone.
    task automatic do_load(input logic [7:0] L, input logic [7:0] prog[$], input bit good_csum,
                           input int gap, input bit poke, output bit ran);
        logic [7:0] stream[$];
        logic [7:0] sum;
        int  n;
        int  nw;
        bit  bad_len, exp_err, ok;
        n       = (L[AW-1:0] == 0) ? (1 << AW) : int'(L[AW-1:0]);
        bad_len = (L >> AW) != 0;
        sum     = L;
        stream.push_back(L);
        if (!bad_len) begin
            for (int k = 0; k < n; k++) begin
                sum = sum + prog[k];
                stream.push_back(prog[k]);
            end
            if (CSUM_EN) stream.push_back(good_csum ? sum : sum + 8'd1);
        end
        exp_err = bad_len || (CSUM_EN && !good_csum);
        nw      = bad_len ? 0 : n;

        wr_q.delete();
        fall_cyc = -1;
        pulse_start();
        send_stream(stream, gap, poke, ok);

        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stream_timeout: accepted %0d of %0d bytes", acc_q.size(), stream.size());
        end
        checks++;
        if (wr_q.size() != nw) begin
            errors++;
            $display("FAIL write_count: got %0d want %0d (L=%h)", wr_q.size(), nw, L);
        end
        for (int k = 0; k < nw && k < wr_q.size() && k + 1 < acc_q.size(); k++) begin
            checks++;
            if (wr_q[k].addr != k || wr_q[k].data != int'(prog[k]) || wr_q[k].cyc != acc_q[k+1]) begin
                errors++;
                $display("FAIL write_%0d: addr/data/cyc=%0d/%h/%0d want %0d/%h/%0d",
                         k, wr_q[k].addr, wr_q[k].data, wr_q[k].cyc, k, prog[k], acc_q[k+1]);
            end
        end
        checks++;
        if (exp_err) begin
            if ({error, cpu_rst, done, busy} !== 4'b1100) begin
                errors++;
                $display("FAIL load_error: err/rst/done/busy=%b%b%b%b want 1100",
                         error, cpu_rst, done, busy);
            end
        end else begin
            if ({error, cpu_rst, done, busy} !== 4'b0001 || acc_q.size() == 0 ||
                fall_cyc != acc_q[acc_q.size()-1]) begin
                errors++;
                $display("FAIL load_run: err/rst/done/busy=%b%b%b%b want 0001, cpu_rst fell at %0d want %0d",
                         error, cpu_rst, done, busy, fall_cyc,
                         acc_q.size() ? acc_q[acc_q.size()-1] : -1);
            end
        end
        ran = !exp_err;
    endtask

    // Called on the first RUN cycle; halt is sampled on the K-th RUN edge.
    task automatic run_halt(input int K);
        logic [CW-1:0] exp;
        exp = CW'((K > MAXCNT) ? MAXCNT : K);
        cpu_halt = 1'b0;
        for (int i = 0; i < K - 1; i++) @(negedge clk);
        cpu_halt = 1'b1;
        @(negedge clk);
        cpu_halt = 1'b0;
        checks++;
        if ({done, cpu_rst, busy, error} !== 4'b1000 || run_cycles !== exp) begin
            errors++;
            $display("FAIL halt_%0d: done/rst/busy/err=%b%b%b%b run=%0d want 1000 run=%0d",
                     K, done, cpu_rst, busy, error, run_cycles, exp);
        end
        cpu_halt = 1'b1;
        repeat (3) @(negedge clk);
        cpu_halt = 1'b0;
        checks++;
        if ({done, cpu_rst} !== 2'b10 || run_cycles !== exp) begin
            errors++;
            $display("FAIL done_hold: done/rst=%b%b run=%0d want 10 run=%0d",
                     done, cpu_rst, run_cycles, exp);
        end
    endtask

    task automatic test_reset();
        s_if.in_valid = 1'b0;
        s_if.in_data  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_if.in_ready, mem_wr, mem_addr, mem_data, cpu_rst, busy, done, error, run_cycles}
            !== {2'b00, {AW{1'b0}}, {DW{1'b0}}, 4'b1000, {CW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_values: rdy=%b wr=%b a=%h d=%h crst=%b busy=%b done=%b err=%b run=%0d",
                     s_if.in_ready, mem_wr, mem_addr, mem_data, cpu_rst, busy, done, error, run_cycles);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] p[$];
        bit ran;
        p = '{8'hA1, 8'hB2, 8'hC3};
        do_load(8'd3, p, 1'b1, 0, 1'b0, ran);
        checks++;
        if (wr_q.size() != 3 || wr_q[1].cyc != wr_q[0].cyc + 1 || wr_q[2].cyc != wr_q[1].cyc + 1) begin
            errors++;
            $display("FAIL basic_consecutive: %0d writes, not on consecutive cycles", wr_q.size());
        end
        if (ran) run_halt(10);
    endtask

    task automatic test_full();
        logic [7:0] p[$];
        bit ran;
        for (int k = 0; k < 32; k++) p.push_back(8'($urandom));
        do_load(8'd0, p, 1'b1, 20, 1'b0, ran);
        if (ran) run_halt(5);
    endtask

    task automatic test_bad_len_busy_start();
        logic [7:0] p[$];
        logic [7:0] none[$];
        bit ran;
        do_load(8'h45, none, 1'b1, 0, 1'b0, ran);
        p = '{8'h5A, 8'h11, 8'h22, 8'h33};
        do_load(8'd4, p, 1'b1, 0, 1'b1, ran);
        if (ran) run_halt(3);
    endtask

    task automatic test_checksum();
        logic [7:0] p[$];
        bit ran;
        p = '{8'h10, 8'h20};
        do_load(8'd2, p, 1'b1, 0, 1'b0, ran);
        if (ran) run_halt(2);
        do_load(8'd2, p, 1'b0, 0, 1'b0, ran);
    endtask

    task automatic test_saturate();
        logic [7:0] p[$];
        bit ran;
        p = '{8'h01};
        do_load(8'd1, p, 1'b1, 0, 1'b0, ran);
        if (ran) run_halt(40);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [7:0] p[$];
            logic [7:0] L;
            int  n;
            bit  ran;
            if ($urandom_range(0, 3) == 0) L = {3'($urandom_range(1, 7)), 5'($urandom)};
            else                            L = {3'b000, 5'($urandom)};
            n = (L[AW-1:0] == 0) ? 32 : int'(L[AW-1:0]);
            if ((L >> AW) == 0)
                for (int k = 0; k < n; k++) p.push_back(8'($urandom));
            cpu_halt = 1'($urandom);   // must be ignored outside RUN
            do_load(L, p, $urandom_range(0, 3) != 0, $urandom_range(0, 50), 1'b0, ran);
            cpu_halt = 1'b0;
            if (ran) run_halt($urandom_range(1, 20));
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s[$];
        logic [7:0] p[$];
        bit ok, ran;
        s = '{8'd6, 8'h11, 8'h22};
        pulse_start();
        send_stream(s, 0, 1'b0, ok);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_if.in_valid = ~s_if.in_valid;
            s_if.in_data  = 8'($urandom);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({s_if.in_ready, mem_wr, mem_addr, mem_data, cpu_rst, busy, done, error, run_cycles}
            !== {2'b00, {AW{1'b0}}, {DW{1'b0}}, 4'b1000, {CW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b wr=%b a=%h d=%h crst=%b busy=%b done=%b err=%b run=%0d",
                     s_if.in_ready, mem_wr, mem_addr, mem_data, cpu_rst, busy, done, error, run_cycles);
        end
        @(negedge clk);
        s_if.in_valid = 1'b0;
        rst = 1'b1;
        p = '{8'h9C, 8'h8D, 8'h7E, 8'h6F, 8'h50};
        do_load(8'd5, p, 1'b1, 30, 1'b0, ran);
        if (ran) run_halt(4);
    endtask

    initial begin
        s_if.in_valid = 1'b0;
        s_if.in_data  = '0;
        test_reset();
        test_basic();
        test_full();
        test_bad_len_busy_start();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_saturate();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
